// File: rtl/lsu_mem_master_if.sv
// Bundles the request/response handshake and the data_memory port of the load/store unit.
// The master modport is the LSU's own view; slave is the view of the surrounding environment.
interface lsu_mem_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport master (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_write, mem_address, mem_write_data
    );

    modport slave (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_write, mem_address, mem_write_data
    );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store initiator for a word-wide synchronous data_memory.
// Sub-word stores are read-modify-write; loads are sign/zero extended; little-endian lanes.
module lsu_mem_master #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input logic              clk,
    input logic              rst_n,
    lsu_mem_master_if.master bus_io
);
    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StIssue = 3'd1;
    localparam logic [2:0] StData  = 3'd2;
    localparam logic [2:0] StWrite = 3'd3;
    localparam logic [2:0] StResp  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        req_err;
    logic [4:0]  lane_shift;
    logic [31:0] lane_word;
    logic [31:0] load_val;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;
    logic [31:0] merged;

    // Classify the incoming request: bad size, misalignment or beyond the memory.
    always_comb begin
        req_err = 1'b0;
        case (bus_io.req_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = bus_io.req_addr[0];
            2'b10:   req_err = |bus_io.req_addr[1:0];
            default: req_err = 1'b1;
        endcase
        if ({2'b00, bus_io.req_addr[31:2]} >= MEM_WORDS) begin
            req_err = 1'b1;
        end
    end

    // Lane extraction for loads and lane merge for sub-word stores.
    always_comb begin
        // Halfword requests are aligned here, so the byte shift also selects the half lane.
        lane_shift = {addr_q[1:0], 3'b000};
        lane_word  = bus_io.mem_read_data >> lane_shift;
        case (size_q)
            2'b00: begin
                load_val  = uns_q ? {24'h0, lane_word[7:0]} : {{24{lane_word[7]}}, lane_word[7:0]};
                lane_mask = 32'h0000_00FF << lane_shift;
                lane_data = {24'h0, wdata_q[7:0]} << lane_shift;
            end
            2'b01: begin
                load_val  = uns_q ? {16'h0, lane_word[15:0]}
                                  : {{16{lane_word[15]}}, lane_word[15:0]};
                lane_mask = 32'h0000_FFFF << lane_shift;
                lane_data = {16'h0, wdata_q} << lane_shift;
            end
            default: begin
                load_val  = bus_io.mem_read_data;
                lane_mask = 32'h0;
                lane_data = 32'h0;
            end
        endcase
        merged = (bus_io.mem_read_data & ~lane_mask) | (lane_data & lane_mask);
    end

    // Sequencing: IDLE -> (ISSUE -> DATA ->) (WRITE ->) RESP -> IDLE.
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        size_d      = size_q;
        uns_d       = uns_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            StIdle: begin
                if (bus_io.req_valid) begin
                    write_d = bus_io.req_write;
                    size_d  = bus_io.req_size;
                    uns_d   = bus_io.req_unsigned;
                    addr_d  = bus_io.req_addr;
                    wdata_d = bus_io.req_wdata[15:0];
                    err_d   = req_err;
                    if (req_err) begin
                        rdata_d = 32'h0;
                        state_d = StResp;
                    end else if (bus_io.req_write && bus_io.req_size == 2'b10) begin
                        mem_wdata_d = bus_io.req_wdata;
                        state_d     = StWrite;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: state_d = StData;
            StData: begin
                if (write_q) begin
                    mem_wdata_d = merged;
                    state_d     = StWrite;
                end else begin
                    rdata_d = load_val;
                    state_d = StResp;
                end
            end
            StWrite: begin
                rdata_d = 32'h0;
                state_d = StResp;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and latched request; reset aborts any operation immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            write_q     <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 16'h0;
            err_q       <= 1'b0;
            rdata_q     <= 32'h0;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus_io.req_ready      = (state_q == StIdle);
    assign bus_io.resp_valid     = (state_q == StResp);
    assign bus_io.resp_rdata     = rdata_q;
    assign bus_io.resp_error     = (state_q == StResp) && err_q;
    assign bus_io.mem_write      = (state_q == StWrite);
    assign bus_io.mem_address    = {addr_q[31:2], 2'b00};
    assign bus_io.mem_write_data = mem_wdata_q;
endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: directed table, mid-operation reset, and random traffic
// against a word-array reference model.
module tb_lsu_mem_master;
    localparam int unsigned MemWords = 1024;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lsu_mem_master_if bus_if();

    lsu_mem_master #(.MEM_WORDS(MemWords)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus_if)
    );

    logic [31:0] mem_arr [MemWords];
    logic [31:0] ref_mem [MemWords];
    logic [29:0] mem_idx;
    int checks = 0;
    int errors = 0;

    assign mem_idx = bus_if.mem_address[31:2];

    // data_memory: synchronous read with one-cycle latency, synchronous write.
    always @(posedge clk) begin
        if (bus_if.mem_write && {2'b00, mem_idx} < MemWords) begin
            mem_arr[mem_idx[9:0]] <= bus_if.mem_write_data;
        end
        bus_if.mem_read_data <= ({2'b00, mem_idx} < MemWords) ? mem_arr[mem_idx[9:0]] : 32'h0;
    end

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          nwr;
        logic [31:0] wword;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference: evaluates a request against ref_mem and commits stores to it.
    function automatic void model(input logic w, input logic [1:0] sz, input logic u,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic err, output int lat,
                                  output int nwr, output logic [31:0] wword);
        int unsigned idx;
        int k;
        logic [31:0] word;
        logic [7:0]  b;
        logic [15:0] h;
        idx = {2'b00, a[31:2]};
        k   = int'(a[1:0]);
        err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
              || (idx >= MemWords);
        word  = err ? 32'h0 : ref_mem[idx[9:0]];
        rd    = 32'h0;
        nwr   = 0;
        wword = 32'h0;
        if (err) begin
            lat = 1;
        end else if (!w) begin
            lat = 3;
            if (sz == 2'b00) begin
                b  = word[8*k +: 8];
                rd = u ? {24'h0, b} : {{24{b[7]}}, b};
            end else if (sz == 2'b01) begin
                h  = word[16*(k/2) +: 16];
                rd = u ? {16'h0, h} : {{16{h[15]}}, h};
            end else begin
                rd = word;
            end
        end else begin
            nwr   = 1;
            lat   = (sz == 2'b10) ? 2 : 4;
            wword = word;
            if (sz == 2'b00) wword[8*k +: 8] = wd[7:0];
            else if (sz == 2'b01) wword[16*(k/2) +: 16] = wd[15:0];
            else wword = wd;
            ref_mem[idx[9:0]] = wword;
        end
    endfunction

    // Issue one request from a negedge, scramble inputs after accept, check the whole response.
    task automatic do_req(input string tag, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                          input logic exp_err, input int exp_lat, input int exp_nwr,
                          input logic [31:0] exp_wword);
        int waits;
        int lat;
        int nwr;
        logic seen;
        logic [31:0] waddr;
        logic [31:0] wdat;
        logic [31:0] rd;
        logic er;
        logic rdy;
        waits = 0;
        while (!bus_if.req_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        chk({tag, " wait_ready"}, 32'(waits), 32'd0);
        bus_if.req_valid    = 1'b1;
        bus_if.req_write    = w;
        bus_if.req_size     = sz;
        bus_if.req_unsigned = u;
        bus_if.req_addr     = a;
        bus_if.req_wdata    = wd;
        @(posedge clk);
        #1;
        bus_if.req_valid    = 1'b0;
        bus_if.req_write    = ~w;
        bus_if.req_size     = 2'($urandom);
        bus_if.req_unsigned = ~u;
        bus_if.req_addr     = $urandom;
        bus_if.req_wdata    = $urandom;
        lat   = 0;
        nwr   = 0;
        seen  = 1'b0;
        waddr = 32'h0;
        wdat  = 32'h0;
        rd    = 32'h0;
        er    = 1'b0;
        rdy   = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus_if.mem_write) begin
                nwr++;
                waddr = bus_if.mem_address;
                wdat  = bus_if.mem_write_data;
            end
            if (bus_if.resp_valid) begin
                seen = 1'b1;
                rd   = bus_if.resp_rdata;
                er   = bus_if.resp_error;
                rdy  = bus_if.req_ready;
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " resp_error"}, {31'h0, er}, {31'h0, exp_err});
        chk({tag, " resp_rdata"}, rd, exp_rd);
        chk({tag, " write_count"}, 32'(nwr), 32'(exp_nwr));
        chk({tag, " ready_in_resp"}, {31'h0, rdy}, 32'h0);
        if (exp_nwr != 0) begin
            chk({tag, " write_addr"}, waddr, {a[31:2], 2'b00});
            chk({tag, " write_data"}, wdat, exp_wword);
        end
        @(negedge clk);
        chk({tag, " resp_pulse"}, {31'h0, bus_if.resp_valid}, 32'h0);
        chk({tag, " ready_after"}, {31'h0, bus_if.req_ready}, 32'h1);
        chk({tag, " rdata_held"}, bus_if.resp_rdata, rd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] m_rd;
        logic [31:0] m_ww;
        logic        m_err;
        int          m_lat;
        int          m_nwr;
        logic        rw;
        logic        ru;
        logic [1:0]  rsz;
        logic [31:0] ra;
        logic [31:0] rwd;
        int          r;

        for (int i = 0; i < int'(MemWords); i++) begin
            mem_arr[i] = 32'(i) * 32'h9E37_79B9 ^ 32'h5A5A_0000;
            ref_mem[i] = 32'(i) * 32'h9E37_79B9 ^ 32'h5A5A_0000;
        end
        mem_arr[0] = 32'h8000_00F0;
        ref_mem[0] = 32'h8000_00F0;
        mem_arr[1] = 32'h1122_3344;
        ref_mem[1] = 32'h1122_3344;

        tbl[0]  = '{1'b0, 2'd0, 1'b0, 32'h0,    32'h0,         32'hFFFF_FFF0, 1'b0, 3, 0, 32'h0};
        tbl[1]  = '{1'b0, 2'd1, 1'b1, 32'h2,    32'h0,         32'h0000_8000, 1'b0, 3, 0, 32'h0};
        tbl[2]  = '{1'b0, 2'd2, 1'b0, 32'h0,    32'h0,         32'h8000_00F0, 1'b0, 3, 0, 32'h0};
        tbl[3]  = '{1'b1, 2'd0, 1'b0, 32'h5,    32'h0000_00AB, 32'h0, 1'b0, 4, 1, 32'h1122_AB44};
        tbl[4]  = '{1'b1, 2'd2, 1'b0, 32'hC,    32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1, 32'hDEAD_BEEF};
        tbl[5]  = '{1'b0, 2'd2, 1'b0, 32'hC,    32'h0,         32'hDEAD_BEEF, 1'b0, 3, 0, 32'h0};
        tbl[6]  = '{1'b0, 2'd2, 1'b0, 32'h6,    32'h0,         32'h0, 1'b1, 1, 0, 32'h0};
        tbl[7]  = '{1'b0, 2'd1, 1'b0, 32'h3,    32'h0,         32'h0, 1'b1, 1, 0, 32'h0};
        tbl[8]  = '{1'b0, 2'd2, 1'b0, 32'h1000, 32'h0,         32'h0, 1'b1, 1, 0, 32'h0};
        tbl[9]  = '{1'b0, 2'd3, 1'b0, 32'h0,    32'h0,         32'h0, 1'b1, 1, 0, 32'h0};
        tbl[10] = '{1'b1, 2'd1, 1'b0, 32'h2,    32'hFFFF_1234, 32'h0, 1'b0, 4, 1, 32'h1234_00F0};
        tbl[11] = '{1'b1, 2'd2, 1'b0, 32'h1002, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 0, 32'h0};
        tbl[12] = '{1'b0, 2'd0, 1'b1, 32'h7,    32'h0,         32'h0000_0011, 1'b0, 3, 0, 32'h0};
        tbl[13] = '{1'b0, 2'd1, 1'b0, 32'h4,    32'h0,         32'hFFFF_AB44, 1'b0, 3, 0, 32'h0};

        bus_if.req_valid    = 1'b0;
        bus_if.req_write    = 1'b0;
        bus_if.req_size     = 2'b00;
        bus_if.req_unsigned = 1'b0;
        bus_if.req_addr     = 32'h0;
        bus_if.req_wdata    = 32'h0;
        rst_n = 1'b0;
        #1;
        chk("reset req_ready", {31'h0, bus_if.req_ready}, 32'h1);
        chk("reset resp_valid", {31'h0, bus_if.resp_valid}, 32'h0);
        chk("reset resp_error", {31'h0, bus_if.resp_error}, 32'h0);
        chk("reset resp_rdata", bus_if.resp_rdata, 32'h0);
        chk("reset mem_write", {31'h0, bus_if.mem_write}, 32'h0);
        chk("reset mem_address", bus_if.mem_address, 32'h0);
        chk("reset mem_write_data", bus_if.mem_write_data, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            model(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd,
                  m_rd, m_err, m_lat, m_nwr, m_ww);
            do_req($sformatf("vec%0d", i), tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd,
                   tbl[i].rd, tbl[i].err, tbl[i].lat, tbl[i].nwr, tbl[i].wword);
        end

        // Reset in the DATA cycle of a byte store: the write must never happen.
        bus_if.req_valid    = 1'b1;
        bus_if.req_write    = 1'b1;
        bus_if.req_size     = 2'b00;
        bus_if.req_unsigned = 1'b0;
        bus_if.req_addr     = 32'h9;
        bus_if.req_wdata    = 32'h77;
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort mem_address_before", bus_if.mem_address, 32'h8);
        rst_n = 1'b0;
        #1;
        chk("abort req_ready", {31'h0, bus_if.req_ready}, 32'h1);
        chk("abort resp_valid", {31'h0, bus_if.resp_valid}, 32'h0);
        chk("abort resp_error", {31'h0, bus_if.resp_error}, 32'h0);
        chk("abort resp_rdata", bus_if.resp_rdata, 32'h0);
        chk("abort mem_write", {31'h0, bus_if.mem_write}, 32'h0);
        chk("abort mem_address", bus_if.mem_address, 32'h0);
        chk("abort mem_write_data", bus_if.mem_write_data, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort no_write", {31'h0, bus_if.mem_write}, 32'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        model(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, m_rd, m_err, m_lat, m_nwr, m_ww);
        do_req("after_reset", 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, m_rd, m_err, m_lat, m_nwr, m_ww);

        for (int i = 0; i < 80; i++) begin
            rw  = 1'($urandom);
            ru  = 1'($urandom);
            rwd = $urandom;
            r   = int'($urandom_range(0, 9));
            rsz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            r   = int'($urandom_range(0, 9));
            if (r < 7) ra = $urandom_range(0, 31);
            else if (r < 9) ra = 32'hFF0 + $urandom_range(0, 15);
            else ra = 32'h1000 + $urandom_range(0, 255);
            model(rw, rsz, ru, ra, rwd, m_rd, m_err, m_lat, m_nwr, m_ww);
            do_req($sformatf("rnd%0d", i), rw, rsz, ru, ra, rwd, m_rd, m_err, m_lat, m_nwr, m_ww);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
